team_06_pwm_audio_out: RTL
==========================

// Module: team_06_pwm_audio_out
// PURPOSE
//  Output stage directly downstream of the audio effect block. Buffers processed 8-bit samples in a
//  small FIFO and converts each one to a pulse-width-modulated bit for the external RC filter/speaker.
//  Pops one sample per PWM period; reports underrun when upstream fails to keep the FIFO fed.
// PARAMETERS
//  CLK_DIV     default 1   clocks per PWM count tick (prescaler, >=1); PWM period = 256*CLK_DIV clocks
//  FIFO_DEPTH  default 4   sample FIFO entries (power of 2, >=2)
// PORTS
//  clk           input   1   system clock, all logic on rising edge
//  rst           input   1   asynchronous, active-low reset
//  sample_in     input   8   unsigned sample from the effect stage (audio_out)
//  sample_valid  input   1   sample_in valid this cycle
//  sample_ready  output  1   FIFO can accept; push = sample_valid & sample_ready
//  enable        input   1   1 = PWM running; 0 = output parked low
//  underrun_clr  input   1   clears sticky underrun flag
//  pwm_out       output  1   PWM bit to pad
//  sample_req    output  1   1-cycle pulse at each period boundary (one sample consumed or missed)
//  underrun      output  1   sticky: boundary occurred with FIFO empty
//  fifo_count    output  3   current FIFO occupancy (0..FIFO_DEPTH)
// BEHAVIOUR
//  Reset (rst=0, async): FIFO empty, wr/rd ptrs 0, prescaler 0, cnt=255, duty=0, pwm_out=0,
//   sample_req=0, underrun=0; sample_ready=1 (combinational !full) once rst deasserts.
//  FIFO: push on valid&ready; sample_ready=0 when count==FIFO_DEPTH (valid while full is ignored,
//   data dropped, no error). Ptrs wrap modulo FIFO_DEPTH. Push and pop same cycle: count unchanged.
//  Tick: prescaler counts 0..CLK_DIV-1 while enable=1; tick on the cycle prescaler==CLK_DIV-1.
//  Counter cnt (8b): on tick, cnt<=cnt+1 (wraps 255->0).
//  Boundary = tick with cnt==255. On boundary: sample_req<=1 for one cycle;
//   if count!=0 (pre-cycle value): duty<=FIFO head, pop;
//   else: duty holds previous value, underrun<=1.
//   Push landing in the same cycle as an empty-FIFO boundary is stored, not consumed; underrun still sets.
//  pwm_out <= enable & (cnt < duty), registered: output lags cnt by 1 clock.
//   duty=0 -> constant 0; duty=255 -> high 255 of 256 counts; duty=N -> high N counts per period.
//  enable=0: prescaler<=0, cnt<=255, pwm_out<=0, no pops, no sample_req, no underrun; FIFO still
//   accepts pushes; duty retained. Hence first tick after enable rises is a boundary (immediate load).
//  Dropping enable mid-period aborts the period; sample already in duty is not replayed on resume
//   (resume loads next FIFO entry, or keeps duty + underrun if empty).
//  underrun_clr: underrun<=0 unless a new underrun event occurs the same cycle (set wins).
//  Reset mid-operation: all state returns to reset values immediately; buffered samples discarded.
// TESTING  (CLK_DIV=1, FIFO_DEPTH=4 unless stated)
//  1 Reset: hold rst=0 with valid toggling -> pwm_out=0, ready=1 after release, count=0, underrun=0.
//  2 Push 0x40, enable=1 -> sample_req pulse on 1st enabled cycle, pwm_out high exactly 64 of each
//    256-clk period, count back to 0.
//  3 Push 5 samples back-to-back, enable=0 -> ready=0 after 4th, 5th dropped, count=4; enable ->
//    duties follow samples 1..4 in order, one per 256 clks, sample_req every 256 clks.
//  4 Push 0x00 then 0xFF -> period 1 pwm_out constantly 0; period 2 high 255 clks, low 1 clk.
//  5 One sample then let FIFO empty -> underrun=1 at next boundary, duty held (same waveform);
//    underrun_clr -> 0; simultaneous clr + new underrun -> stays 1.
//  6 CLK_DIV=3, sample 0x10 -> period 768 clks, high 48 clks; enable drop mid-period -> pwm_out 0
//    next clk, cnt parked; rst pulse mid-period -> all outputs reset values asynchronously.

Source files
------------

// File: rtl/team_06_pwm_audio_out.sv
// rtl/team_06_pwm_audio_out.sv - sample FIFO feeding an 8-bit PWM audio output stage
//
// Purpose: buffers processed 8-bit samples and emits one PWM period per sample
// (256 count ticks, each tick CLK_DIV clocks long). The next sample is taken from the
// FIFO at every period boundary; an empty FIFO at a boundary raises a sticky underrun.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   sample_in     unsigned sample from the effect stage
//   sample_valid  sample_in valid this cycle
//   sample_ready  FIFO not full; a push happens on sample_valid & sample_ready
//   enable        1 = PWM running, 0 = output parked low (FIFO still fills)
//   underrun_clr  clears the sticky underrun flag
//   pwm_out       registered PWM bit to the pad
//   sample_req    one-cycle pulse at each period boundary
//   underrun      sticky: a boundary found the FIFO empty
//   fifo_count    current FIFO occupancy

module team_06_pwm_audio_out #(
    parameter int CLK_DIV    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    input  logic       enable,
    input  logic       underrun_clr,
    output logic       pwm_out,
    output logic       sample_req,
    output logic       underrun,
    output logic [2:0] fifo_count
);

    localparam int             AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int             PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [2:0]     DEPTH     = 3'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [2:0]    count;
    logic [PW-1:0] presc;
    logic [7:0]    cnt;
    logic [7:0]    duty;

    logic push;
    logic pop;
    logic tick;
    logic boundary;
    logic fifo_empty;

    assign sample_ready = (count != DEPTH);
    assign fifo_count   = count;
    assign fifo_empty   = (count == 3'd0);

    assign push     = sample_valid & sample_ready;
    assign tick     = enable & (presc == PRESC_MAX);
    // cnt parks at 255 while disabled, so the first tick after enable is a boundary.
    assign boundary = tick & (cnt == 8'hFF);
    assign pop      = boundary & ~fifo_empty;

    // Sample storage needs no reset: occupancy and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc      <= '0;
            cnt        <= 8'hFF;
            duty       <= 8'h00;
            pwm_out    <= 1'b0;
            sample_req <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (!enable) begin
                presc <= '0;
                cnt   <= 8'hFF;
            end else if (tick) begin
                presc <= '0;
                cnt   <= cnt + 8'd1;
            end else begin
                presc <= presc + 1'b1;
            end

            if (pop) begin
                duty <= mem[rd_ptr];
            end

            sample_req <= boundary;

            // A fresh underrun event outranks a clear in the same cycle.
            if (boundary && fifo_empty) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end

            pwm_out <= enable & (cnt < duty);
        end
    end

endmodule
